// File: rtl/fft_arith_pkg.sv
// Shared arithmetic definitions for the FFT datapath blocks: default width,
// divider state encoding and Q15 saturation limits.
package fft_arith_pkg;
    localparam int W16 = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    localparam logic [15:0] Q_MAX = 16'h7FFF;
    localparam logic [15:0] Q_MIN = 16'h8000;
endpackage

// File: rtl/sdiv_iter_if.sv
// Request/response bundle of the iterative signed divider: operands in,
// quotient/remainder/flags out, each side with its own valid/ready pair.
interface sdiv_iter_if
    import fft_arith_pkg::*;
#(
    parameter int W = W16
);
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     quotient;
    logic [W-1:0]     remainder;
    logic             ovf;
    logic             dbz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf, dbz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf, dbz
    );
endinterface

// File: rtl/sdiv_step.sv
// One restoring-division step on magnitudes: subtract the divisor when it
// fits into the partial remainder and report the resulting quotient bit.
module sdiv_step
    import fft_arith_pkg::*;
#(
    parameter int W = W16
) (
    input  logic [W:0]   partial,
    input  logic [W-1:0] dsr_mag,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);
    logic [W:0] diff;

    always_comb begin
        diff     = partial - {1'b0, dsr_mag};
        q_bit    = (partial >= {1'b0, dsr_mag});
        // The result is always below |divisor|, so the top bit is always zero.
        rem_next = q_bit ? diff[W-1:0] : partial[W-1:0];
    end
endmodule

// File: rtl/sdiv_iter.sv
// Iterative signed divider (2W / W -> W quotient and remainder), one quotient
// bit per cycle. Define DIV_SAT_EN to clamp overflowing quotients to Q15 limits.
module sdiv_iter
    import fft_arith_pkg::*;
#(
    parameter int W = W16
) (
    input  logic        clk,
    input  logic        rst_n,
    sdiv_iter_if.slave  bus
);
    localparam int CW = $clog2(2 * W);
    localparam logic [W-1:0] SAT_MAX = (W == W16) ? W'(Q_MAX) : {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = (W == W16) ? W'(Q_MIN) : {1'b1, {(W-1){1'b0}}};

    div_state_t     state_reg, state_next;
    logic [CW-1:0]  cnt_reg;
    logic [2*W-1:0] dvd_reg, quo_reg;
    logic [W-1:0]   dsr_reg, rem_reg, raw_low_reg;
    logic           neg_q_reg, neg_r_reg, dbz_pend_reg;
    logic [W-1:0]   q_out_reg, r_out_reg;
    logic           ovf_reg, dbz_reg;

    logic           accept;
    logic [2*W-1:0] dvd_mag;
    logic [W-1:0]   dsr_mag;
    logic [W-1:0]   rem_next;
    logic           q_bit;
    logic [2*W-1:0] q_signed;
    logic           q_ovf;
    logic [W-1:0]   q_final, r_signed;

    sdiv_step #(.W(W)) u_step (
        .partial  ({rem_reg, dvd_reg[2*W-1]}),
        .dsr_mag  (dsr_reg),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // -2^(2W-1) negates to itself, which read unsigned is exactly its magnitude.
    assign dvd_mag = bus.dividend[2*W-1] ? -bus.dividend : bus.dividend;
    assign dsr_mag = bus.divisor[W-1]    ? -bus.divisor  : bus.divisor;

    always_comb begin
        q_signed = neg_q_reg ? -quo_reg : quo_reg;
        // Fits in W bits only if the top W+1 bits are a pure sign extension.
        q_ovf    = !((&q_signed[2*W-1:W-1]) || !(|q_signed[2*W-1:W-1]));
`ifdef DIV_SAT_EN
        q_final  = q_ovf ? (neg_q_reg ? SAT_MIN : SAT_MAX) : q_signed[W-1:0];
`else
        q_final  = q_signed[W-1:0];
`endif
        r_signed = neg_r_reg ? -rem_reg : rem_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = (bus.divisor == '0) ? FIX : CALC;
                end
            end
            CALC: if (cnt_reg == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            dvd_reg      <= '0;
            quo_reg      <= '0;
            dsr_reg      <= '0;
            rem_reg      <= '0;
            raw_low_reg  <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            dbz_pend_reg <= 1'b0;
            q_out_reg    <= '0;
            r_out_reg    <= '0;
            ovf_reg      <= 1'b0;
            dbz_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (accept) begin
                    dvd_reg      <= dvd_mag;
                    dsr_reg      <= dsr_mag;
                    rem_reg      <= '0;
                    quo_reg      <= '0;
                    cnt_reg      <= CW'(2 * W - 1);
                    neg_q_reg    <= bus.dividend[2*W-1] ^ bus.divisor[W-1];
                    neg_r_reg    <= bus.dividend[2*W-1];
                    raw_low_reg  <= bus.dividend[W-1:0];
                    dbz_pend_reg <= (bus.divisor == '0);
                end
                CALC: begin
                    rem_reg <= rem_next;
                    quo_reg <= {quo_reg[2*W-2:0], q_bit};
                    dvd_reg <= {dvd_reg[2*W-2:0], 1'b0};
                    cnt_reg <= cnt_reg - 1'b1;
                end
                FIX: begin
                    if (dbz_pend_reg) begin
                        q_out_reg <= neg_r_reg ? SAT_MIN : SAT_MAX;
                        r_out_reg <= raw_low_reg;
                        ovf_reg   <= 1'b0;
                        dbz_reg   <= 1'b1;
                    end else begin
                        q_out_reg <= q_final;
                        r_out_reg <= r_signed;
                        ovf_reg   <= q_ovf;
                        dbz_reg   <= 1'b0;
                    end
                end
                DONE: if (bus.out_ready) begin
                    ovf_reg <= 1'b0;
                    dbz_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = q_out_reg;
    assign bus.remainder = r_out_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.dbz       = dbz_reg;
endmodule

// File: tb/tb_sdiv_iter.sv
// Directed and random checks of sdiv_iter (W=16) against a scoreboard of
// expected results; honours DIV_SAT_EN for the overflow expectation.
module tb_sdiv_iter;
    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        ovf;
        logic        dbz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total_cnt = 0;
    int   pass_cnt = 0;
    exp_t sb[$];

    sdiv_iter_if #(.W(16)) bus ();

    sdiv_iter #(.W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    function automatic exp_t mk(logic [15:0] q, logic [15:0] r, logic ovf, logic dbz, int lat);
        exp_t e;
        e.q = q; e.r = r; e.ovf = ovf; e.dbz = dbz; e.lat = lat;
        return e;
    endfunction

    // Reference model using wide signed arithmetic, which truncates toward zero.
    function automatic exp_t model(logic [31:0] a, logic [15:0] b);
        exp_t   e;
        longint sa = longint'($signed(a));
        longint sbv = longint'($signed(b));
        longint qq, rr;
        if (b == 16'h0) begin
            e = mk((sa < 0) ? 16'h8000 : 16'h7FFF, a[15:0], 1'b0, 1'b1, 1);
        end else begin
            qq = sa / sbv;
            rr = sa % sbv;
            e = mk(qq[15:0], rr[15:0], (qq > 32767) || (qq < -32768), 1'b0, 33);
`ifdef DIV_SAT_EN
            if (e.ovf) e.q = (qq < 0) ? 16'h8000 : 16'h7FFF;
`endif
        end
        return e;
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [15:0] b, input exp_t e);
        int n = 0;
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int lat, output exp_t e);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            e = mk(16'h0, 16'h0, 1'b0, 1'b0, 0);
        end else begin
            e = sb.pop_front();
        end
        $display("txn %s: lat=%0d q=%h r=%h ovf=%b dbz=%b", tag, lat,
                 bus.quotient, bus.remainder, bus.ovf, bus.dbz);
        check({tag, "_lat"}, 32'(lat), 32'(e.lat));
        check({tag, "_q"}, 32'(bus.quotient), 32'(e.q));
        check({tag, "_r"}, 32'(bus.remainder), 32'(e.r));
        check({tag, "_flags"}, {30'd0, bus.ovf, bus.dbz}, {30'd0, e.ovf, e.dbz});
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic retire(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_retired"}, {29'd0, bus.out_valid, bus.ovf, bus.dbz}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [15:0] b, input exp_t e);
        int   lat;
        exp_t got;
        start_op(a, b, e);
        wait_result(lat);
        check_result(tag, lat, got);
        retire(tag);
    endtask

    initial begin
        int   lat;
        exp_t e;
        logic [31:0] ra;
        logic [15:0] rb;
        logic [15:0] ovf_q;
`ifdef DIV_SAT_EN
        ovf_q = 16'h7FFF;
`else
        ovf_q = 16'h0000;
`endif
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {bus.in_ready, bus.out_valid, bus.ovf, bus.dbz, bus.quotient, bus.remainder},
              {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0});
        rst_n = 1'b1;

        run_op("pos_pos", 32'd1000, 16'd7, mk(16'h008E, 16'h0006, 1'b0, 1'b0, 33));
        run_op("neg_pos", -32'sd1000, 16'd7, mk(16'hFF72, 16'hFFFA, 1'b0, 1'b0, 33));
        run_op("pos_neg", 32'd1000, -16'sd7, mk(16'hFF72, 16'h0006, 1'b0, 1'b0, 33));
        run_op("neg_neg", -32'sd1000, -16'sd7, mk(16'h008E, 16'hFFFA, 1'b0, 1'b0, 33));
        run_op("min_q", 32'h4000_0000, 16'h8000, mk(16'h8000, 16'h0000, 1'b0, 1'b0, 33));
        run_op("ovf", 32'h4000_0000, 16'h0001, mk(ovf_q, 16'h0000, 1'b1, 1'b0, 33));
        run_op("dbz_pos", 32'd5, 16'd0, mk(16'h7FFF, 16'h0005, 1'b0, 1'b1, 1));
        run_op("dbz_neg", -32'sd5, 16'd0, mk(16'h8000, 16'hFFFB, 1'b0, 1'b1, 1));
        run_op("min_dvd", 32'h8000_0000, 16'hFFFF, model(32'h8000_0000, 16'hFFFF));

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = 16'($urandom_range(1, 65535));
            if (i < 2) ra = 32'($signed(ra[19:0]));
            run_op($sformatf("rand%0d", i), ra, rb, model(ra, rb));
        end

        // Back-pressure: result must hold while out_ready stays low.
        start_op(32'd30000, -16'sd3, mk(16'hD8F0, 16'h0000, 1'b0, 1'b0, 33));
        wait_result(lat);
        check_result("hold", lat, e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("hold_stable%0d", i),
                  {bus.out_valid, bus.in_ready, bus.ovf, bus.dbz, bus.quotient, bus.remainder},
                  {1'b1, 1'b0, e.ovf, e.dbz, e.q, e.r});
        end
        bus.dividend = 32'd100;
        bus.divisor = 16'd10;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        sb.push_back(mk(16'h000A, 16'h0000, 1'b0, 1'b0, 33));
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("pend_idle", {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 1'b1, 1'b0});
        @(negedge clk);
        check("pend_accepted", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        wait_result(lat);
        check_result("pend", lat, e);
        retire("pend");

        // Reset in the middle of CALC drops the operation.
        start_op(32'd1000, 16'd7, mk(16'h008E, 16'h0006, 1'b0, 1'b0, 33));
        void'(sb.pop_back());
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_reset", {bus.in_ready, bus.out_valid, bus.ovf, bus.dbz, bus.quotient},
              {1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_reset", 32'd100, 16'd10, mk(16'h000A, 16'h0000, 1'b0, 1'b0, 33));

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
